// File: rtl/div_pkg.sv
// Shared types and width helpers for the sequential restoring divider.
// Optional build macro: DIV_TRUNC_EN (truncated-approximate division).
package div_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Dividend/quotient width for a given divisor width.
    function automatic int quot_width(input int w);
        return 2 * w;
    endfunction

    // Width of the step counter, which counts down from 2W-1 to 0.
    function automatic int cnt_width(input int w);
        return (2 * w > 1) ? $clog2(2 * w) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, then subtract the divisor if it fits.
module div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   pr_in,
    input  logic         dvd_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   pr_out,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] dvs_ext;

    // Compare and conditionally subtract in W+1 bits. A set top bit of pr_in
    // would mean the shifted value already exceeds any W-bit divisor; the
    // restoring loop keeps pr below the divisor so that bit stays clear.
    always_comb begin
        shifted = {pr_in[W-1:0], dvd_bit};
        dvs_ext = {1'b0, divisor};
        q_bit   = pr_in[W] | (shifted >= dvs_ext);
        pr_out  = q_bit ? (shifted - dvs_ext) : shifted;
    end

endmodule

// File: rtl/seq_restoring_div.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per cycle, valid/ready on both operand and result sides.
// Optional build macro: DIV_TRUNC_EN skips the low TRUNC_BITS quotient bits.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid and its data until that edge, and
// ready never depends combinationally on valid.
module seq_restoring_div
    import div_pkg::*;
#(
    parameter int W          = 8,
    parameter int TRUNC_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*W-1:0]       dividend,
    input  logic [W-1:0]         divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*W-1:0]       quotient,
    output logic [W-1:0]         remainder,
    output logic                 div_by_zero
);

    localparam int QW = quot_width(W);
    localparam int CW = cnt_width(W);

`ifdef DIV_TRUNC_EN
    // Low dividend bits below TRUNC_BITS are never shifted in.
    localparam int SKIP = TRUNC_BITS;
`else
    // Exact division consumes every dividend bit.
    localparam int SKIP = TRUNC_BITS * 0;
`endif

    localparam logic [CW-1:0] CNT_START = CW'(QW - SKIP - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [QW-1:0]   dvd_q;
    logic [W-1:0]    dvs_q;
    logic [W:0]      pr;
    logic [QW-1:0]   quo;
    logic            dbz_q;

    logic [W:0]      pr_nxt;
    logic            q_bit;

    // Restoring step on the current partial remainder and dividend MSB.
    div_step #(
        .W (W)
    ) u_step (
        .pr_in   (pr),
        .dvd_bit (dvd_q[QW-1]),
        .divisor (dvs_q),
        .pr_out  (pr_nxt),
        .q_bit   (q_bit)
    );

    // Control FSM with registered handshake flags and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            pr          <= '0;
            quo         <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        dvd_q    <= dividend;
                        dvs_q    <= divisor;
                        if (divisor == '0) begin
                            // Divide-by-zero: result is known immediately.
                            quo   <= '1;
                            pr    <= {1'b0, dividend[W-1:0]};
                            dbz_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            quo   <= '0;
                            pr    <= '0;
                            dbz_q <= 1'b0;
                            cnt   <= CNT_START;
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    pr    <= pr_nxt;
                    quo   <= {quo[QW-2:0], q_bit};
                    dvd_q <= {dvd_q[QW-2:0], 1'b0};
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    if (!out_valid) begin
                        // First DONE cycle: publish the result registers.
                        out_valid   <= 1'b1;
                        quotient    <= dbz_q ? quo : (quo << SKIP);
                        remainder   <= pr[W-1:0];
                        div_by_zero <= dbz_q;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_div.sv
// Self-checking bench for seq_restoring_div: directed vectors, an arithmetic
// reference model feeding an expected queue, and a per-cycle result checker.
// Optional build macro: DIV_TRUNC_EN (bench follows the truncated model).
module tb_seq_restoring_div;

  localparam int W  = 8;
  localparam int QW = 2 * W;
  localparam int T  = 4;
`ifdef DIV_TRUNC_EN
  localparam int SKIP = T;
`else
  localparam int SKIP = 0;
`endif
  localparam int LAT = QW - SKIP + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  // Expected results packed as {div_by_zero, quotient, remainder}.
  logic [QW+W:0] exp_q[$];

  seq_restoring_div #(
    .W          (W),
    .TRUNC_BITS (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: plain integer division on the bits the divider consumes.
  function automatic logic [QW+W:0] model(input logic [QW-1:0] dvd, input logic [W-1:0] dvs);
    int unsigned top;
    int unsigned q;
    int unsigned r;
    if (dvs == 0) return {1'b1, {QW{1'b1}}, dvd[W-1:0]};
    top = int'(dvd) >> SKIP;
    q   = (top / int'(dvs)) << SKIP;
    r   = top % int'(dvs);
    return {1'b0, q[QW-1:0], r[W-1:0]};
  endfunction

  // Scoreboard: every cycle a result is presented, compare it to the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(out_valid), 64'd0);
      end else begin
        chk("quotient", 64'(quotient), 64'(exp_q[0][QW+W-1:W]));
        chk("remainder", 64'(remainder), 64'(exp_q[0][W-1:0]));
        chk("div_by_zero", 64'(div_by_zero), 64'(exp_q[0][QW+W]));
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Driver: issue one operation, measure latency, optionally hold off out_ready.
  task automatic do_op(input logic [QW-1:0] dvd, input logic [W-1:0] dvs,
                       input int exp_lat, input int hold, input int spam);
    int lat;
    @(posedge clk); #1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    dividend  = dvd;
    divisor   = dvs;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back(model(dvd, dvs));
    @(posedge clk); #1;
    in_valid = (spam != 0);
    dividend = QW'($urandom_range(0, 65535));
    divisor  = W'($urandom_range(0, 255));
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("in_ready_hold", 64'(in_ready), 64'd0);
        chk("out_valid_hold", 64'(out_valid), 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("out_valid_after_accept", 64'(out_valid), 64'd0);
    chk("in_ready_after_accept", 64'(in_ready), 64'd1);
  endtask

  task automatic chk_reset_values();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_div_by_zero", 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    logic [QW+W:0] m;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values();
    rst = 1'b0;

    // Hand-computed pins on the model itself.
    m = model(16'd1000, 8'd7);
`ifdef DIV_TRUNC_EN
    chk("pin_1000_7_q", 64'(m[QW+W-1:W]), 64'd128);
`else
    chk("pin_1000_7_q", 64'(m[QW+W-1:W]), 64'd142);
    m = model(16'd65535, 8'd255);
    chk("pin_65535_255_q", 64'(m[QW+W-1:W]), 64'd257);
    m = model(16'd100, 8'd200);
    chk("pin_100_200_r", 64'(m[W-1:0]), 64'd100);
`endif
    m = model(16'd1000, 8'd7);
    chk("pin_1000_7_r", 64'(m[W-1:0]), 64'd6);
    m = model(16'd5, 8'd0);
    chk("pin_5_0_q", 64'(m[QW+W-1:W]), 64'hFFFF);
    chk("pin_5_0_r", 64'(m[W-1:0]), 64'd5);

    // Directed vectors.
    do_op(16'd1000,  8'd7,   LAT, 0, 0);
    do_op(16'd65535, 8'd1,   LAT, 0, 0);
    do_op(16'd65535, 8'd255, LAT, 0, 0);
    do_op(16'd100,   8'd200, LAT, 0, 0);
    do_op(16'd5,     8'd0,   1,   0, 0);
    // Backpressure with stray in_valid during BUSY/DONE.
    do_op(16'd1000,  8'd7,   LAT, 10, 1);

    // Reset five cycles into BUSY, then a fresh operation.
    @(posedge clk); #1;
    dividend  = 16'd1000;
    divisor   = 8'd7;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk_reset_values();
    @(posedge clk); #1;
    chk_reset_values();
    rst = 1'b0;
    do_op(16'd300, 8'd3, LAT, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("results_outstanding", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
